// File: rtl/sha256_msg_sched.sv
// SHA-256 message schedule generator: loads one 512-bit block and streams
// W[0..ROUNDS-1] over a valid/ready port using a 16-word sliding window.
module sha256_msg_sched #(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [511:0] block_in,
  output logic         busy,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         done,
  output logic [1:0]   fsm_state
);

  // Handshake: a word transfers on any rising edge where w_valid && w_ready;
  // while w_valid is high and w_ready is low, w_data and w_idx hold steady.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] LAST = 6'(ROUNDS - 1);

  state_t      state;
  logic [31:0] window [16];
  logic [5:0]  t;
  logic [31:0] nw;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  // window[k] holds W[t+k], so the next word needed is W[t+16].
  always_comb begin
    nw = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      t       <= 6'd0;
      busy    <= 1'b0;
      w_valid <= 1'b0;
      done    <= 1'b0;
      for (int k = 0; k < 16; k++) window[k] <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            for (int k = 0; k < 16; k++) window[k] <= block_in[511 - 32*k -: 32];
            t       <= 6'd0;
            busy    <= 1'b1;
            w_valid <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (w_ready) begin
            for (int k = 0; k < 15; k++) window[k] <= window[k+1];
            window[15] <= nw;
            if (t == LAST) begin
              w_valid <= 1'b0;
              done    <= 1'b1;
              state   <= DONE;
            end else begin
              t <= t + 6'd1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          w_valid <= 1'b0;
          done    <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign w_data    = window[0];
  assign w_idx     = t;
  assign fsm_state = state;

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Bench for sha256_msg_sched: a full-array SHA-256 schedule model feeds an
// expected queue; known vectors, stalls, mid-run start, async reset, back-to-back.
module tb_sha256_msg_sched;

  localparam int ROUNDS = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [511:0] block_in = '0;
  logic         busy, w_valid, w_ready, done;
  logic [31:0]  w_data;
  logic [5:0]   w_idx;
  logic [1:0]   fsm_state;

  sha256_msg_sched #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .block_in(block_in),
    .busy(busy), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .w_idx(w_idx), .done(done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got      [ROUNDS];
  logic [31:0] got_abc  [ROUNDS];
  logic [31:0] got_ones [ROUNDS];
  int          cyc_used;

  typedef struct {
    int          blk;
    int          idx;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: whole schedule array straight from the recurrence.
  function automatic logic [31:0] m_rotr(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic void build_sched(input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++) begin
      a = m_rotr(w[i-15], 7) ^ m_rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      b = m_rotr(w[i-2], 17) ^ m_rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = b + w[i-7] + a + w[i-16];
    end
    for (int i = 0; i < ROUNDS; i++) exp_q.push_back(w[i]);
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  task automatic start_block(input logic [511:0] blk);
    block_in = blk;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    block_in = rand_block();
    check("latency_valid", 32'(w_valid), 32'd1);
    check("first_idx", 32'(w_idx), 32'd0);
  endtask

  task automatic run_block(input int rand_ready, input int poke_at, input int rst_at,
                           input int b2b, input logic [511:0] nxt);
    int          accepted;
    int          cycles;
    bit          aborted;
    logic        pv, pr;
    logic [31:0] pd;
    logic [5:0]  pi;
    logic [31:0] e;
    accepted = 0; cycles = 0; aborted = 0; pv = 0; pr = 0; pd = '0; pi = '0;
    while (accepted < ROUNDS && cycles < 2000) begin
      start = 1'b0;
      if (rst_at >= 0 && w_valid && int'(w_idx) == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valid", 32'(w_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_data", w_data, 32'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_idle_busy", 32'(busy), 32'd0);
        aborted = 1;
        break;
      end
      if (pv && !pr) begin
        check("stall_valid", 32'(w_valid), 32'd1);
        check("stall_data", w_data, pd);
        check("stall_idx", 32'(w_idx), 32'(pi));
      end
      w_ready = (rand_ready != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (poke_at >= 0 && w_valid && int'(w_idx) == poke_at) begin
        start    = 1'b1;
        block_in = {16{32'hDEADBEEF}};
      end
      if (w_valid && w_ready) begin
        check("word_idx", 32'(w_idx), 32'(accepted));
        if (exp_q.size() == 0) begin
          e = ~w_data;
          $display("FAIL scoreboard_empty: got 0x%08h expected no word", w_data);
        end else begin
          e = exp_q.pop_front();
        end
        check("word_data", w_data, e);
        got[accepted] = w_data;
        accepted++;
      end
      pv = w_valid; pr = w_ready; pd = w_data; pi = w_idx;
      @(posedge clk); #1;
      cycles++;
    end
    start    = 1'b0;
    w_ready  = 1'b0;
    cyc_used = cycles;
    if (!aborted) begin
      check("words_accepted", 32'(accepted), 32'(ROUNDS));
      check("done_pulse", 32'(done), 32'd1);
      check("done_valid_low", 32'(w_valid), 32'd0);
      check("done_busy", 32'(busy), 32'd1);
      if (b2b != 0) begin
        block_in = nxt;
        start    = 1'b1;
      end
      @(posedge clk); #1;
      check("done_clear", 32'(done), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_valid", 32'(w_valid), 32'd0);
      if (b2b != 0) begin
        @(posedge clk); #1;
        start    = 1'b0;
        block_in = rand_block();
        check("b2b_valid", 32'(w_valid), 32'd1);
        check("b2b_idx", 32'(w_idx), 32'd0);
      end
    end
  endtask

  initial begin
    logic [511:0] abc, ones, a, b;
    logic [31:0]  act;
    abc  = {32'h61626380, 448'h0, 32'h00000018};
    ones = {16{32'hFFFFFFFF}};
    w_ready = 1'b0;

    vecs[0] = '{0, 0,  32'h61626380};
    vecs[1] = '{0, 1,  32'h00000000};
    vecs[2] = '{0, 15, 32'h00000018};
    vecs[3] = '{0, 16, 32'h61626380};
    vecs[4] = '{0, 17, 32'h000F0000};
    vecs[5] = '{1, 0,  32'hFFFFFFFF};
    vecs[6] = '{1, 15, 32'hFFFFFFFF};
    vecs[7] = '{1, 16, 32'h203FFFFC};

    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_valid", 32'(w_valid), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_data", w_data, 32'd0);
    check("reset_idx", 32'(w_idx), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // "abc" block, full throughput
    build_sched(abc);
    start_block(abc);
    run_block(0, -1, -1, 0, '0);
    check("throughput", 32'(cyc_used), 32'(ROUNDS));
    for (int i = 0; i < ROUNDS; i++) got_abc[i] = got[i];

    // same block with random stalls
    build_sched(abc);
    start_block(abc);
    run_block(1, -1, -1, 0, '0);

    // all-ones block exercises rotate wrap and carry drop
    build_sched(ones);
    start_block(ones);
    run_block(0, -1, -1, 0, '0);
    for (int i = 0; i < ROUNDS; i++) got_ones[i] = got[i];

    for (int i = 0; i < 8; i++) begin
      act = (vecs[i].blk == 0) ? got_abc[vecs[i].idx] : got_ones[vecs[i].idx];
      check($sformatf("vec_blk%0d_w%0d", vecs[i].blk, vecs[i].idx), act, vecs[i].exp);
    end

    // start pulsed mid-run is ignored
    a = rand_block();
    build_sched(a);
    start_block(a);
    run_block(1, 5, -1, 0, '0);

    // async reset mid-run, then a fresh block
    a = rand_block();
    build_sched(a);
    start_block(a);
    run_block(0, -1, 30, 0, '0);
    a = rand_block();
    build_sched(a);
    start_block(a);
    run_block(1, -1, -1, 0, '0);

    // back-to-back blocks, start held from the DONE cycle onwards
    a = rand_block();
    b = rand_block();
    build_sched(a);
    build_sched(b);
    start_block(a);
    run_block(1, -1, -1, 1, b);
    run_block(1, -1, -1, 0, '0);

    for (int n = 0; n < 2; n++) begin
      a = rand_block();
      build_sched(a);
      start_block(a);
      run_block(1, -1, -1, 0, '0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
